// File: rtl/conv_encoder_k3.sv
// -----------------------------------------------------------------------------
// conv_encoder_k3
// Rate-1/2, constraint-length-3 convolutional encoder. Takes a framed serial
// bit stream, optionally appends two zero tail bits per frame so the trellis
// terminates in state 00, and emits one 2-bit symbol {X,Y} per encoded bit
// through a valid/ready output stage.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous, active-high reset
//   bit_i        information bit
//   bit_valid_i  bit_i valid
//   bit_last_i   bit_i is the last bit of its frame
//   bit_ready_o  encoder accepts bit_i this cycle
//   sym_o        encoded symbol {X,Y}
//   sym_valid_o  sym_o valid
//   sym_last_o   sym_o is the final symbol of the frame
//   sym_ready_i  downstream accepts sym_o
//   busy_o       frame in progress or an output symbol pending
//   frame_len_o  symbol count of the last completed frame (saturating)
// -----------------------------------------------------------------------------
module conv_encoder_k3 #(
  parameter logic [2:0] G_X     = 3'b111,  // bit2 = u, bit1 = s0, bit0 = s1
  parameter logic [2:0] G_Y     = 3'b101,
  parameter bit         TAIL_EN = 1'b1,
  parameter int         CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  input  logic             bit_last_i,
  output logic             bit_ready_o,
  output logic [1:0]       sym_o,
  output logic             sym_valid_o,
  output logic             sym_last_o,
  input  logic             sym_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] frame_len_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_TAIL = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [1:0]       state_q, state_d;   // {s1, s0}; s0 is the most recent bit
  logic [1:0]       sym_d;
  logic             last_d;
  logic             tail_q, tail_d;     // 0 = first tail bit next, 1 = second
  logic [CNT_W-1:0] cnt_q;

  logic             out_free;
  logic             accept;
  logic             handshake;
  logic             load;
  logic             u;
  logic [2:0]       taps;
  logic [CNT_W-1:0] cnt_inc;

  // The output register may take a new symbol when empty or being drained.
  assign out_free    = !sym_valid_o || sym_ready_i;
  assign bit_ready_o = out_free && (fsm_q == S_IDLE || fsm_q == S_DATA);
  assign accept      = bit_valid_i && bit_ready_o;
  assign handshake   = sym_valid_o && sym_ready_i;
  assign busy_o      = (fsm_q != S_IDLE) || sym_valid_o;
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    sym_d   = sym_o;
    last_d  = sym_last_o;
    tail_d  = tail_q;
    load    = 1'b0;
    u       = 1'b0;

    case (fsm_q)
      S_IDLE, S_DATA: begin
        if (accept) begin
          load = 1'b1;
          u    = bit_i;
          if (bit_last_i) begin
            if (TAIL_EN) begin
              fsm_d  = S_TAIL;
              tail_d = 1'b0;
            end else begin
              fsm_d  = S_IDLE;
            end
            last_d = !TAIL_EN;
          end else begin
            fsm_d  = S_DATA;
            last_d = 1'b0;
          end
        end
      end
      S_TAIL: begin
        // Tail bits are zeros pushed in whenever the output stage has room.
        if (out_free) begin
          load = 1'b1;
          if (tail_q) begin
            last_d = 1'b1;
            fsm_d  = S_IDLE;
          end else begin
            last_d = 1'b0;
            tail_d = 1'b1;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase

    taps = {u, state_q[0], state_q[1]};
    if (load) begin
      sym_d   = {^(taps & G_X), ^(taps & G_Y)};
      // Every frame ends with the trellis back in 00, tail or no tail.
      state_d = (fsm_d == S_IDLE) ? 2'b00 : {state_q[0], u};
    end
  end

  // NOTE: registers are updated with non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fsm_q       <= S_IDLE;
      state_q     <= 2'b00;
      tail_q      <= 1'b0;
      sym_o       <= 2'b00;
      sym_valid_o <= 1'b0;
      sym_last_o  <= 1'b0;
      cnt_q       <= '0;
      frame_len_o <= '0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      tail_q     <= tail_d;
      sym_o      <= sym_d;
      sym_last_o <= last_d;

      if (load) begin
        sym_valid_o <= 1'b1;
      end else if (handshake) begin
        sym_valid_o <= 1'b0;
      end

      // A symbol loaded on the closing edge belongs to the next frame and
      // is counted when its own handshake happens.
      if (handshake) begin
        if (sym_last_o) begin
          frame_len_o <= cnt_inc;
          cnt_q       <= '0;
        end else begin
          cnt_q       <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_k3.sv
module tb_conv_encoder_k3;

  localparam logic [2:0] GX = 3'b111;
  localparam logic [2:0] GY = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, bit_d, bv, blast, sym_ready, sel;
  logic bv0, bv1;
  logic br0, sv0, sl0, busy0;
  logic [1:0] sym0;
  logic [15:0] fl0;
  logic br1, sv1, sl1, busy1;
  logic [1:0] sym1;
  logic [2:0] fl1;

  // sel = 0 drives the tailed encoder, sel = 1 the untailed 3-bit-counter one.
  assign bv0 = bv & ~sel;
  assign bv1 = bv & sel;

  logic br_s, sv_s, busy_s;
  logic [1:0] sym_s;
  assign br_s   = sel ? br1 : br0;
  assign sv_s   = sel ? sv1 : sv0;
  assign busy_s = sel ? busy1 : busy0;
  assign sym_s  = sel ? sym1 : sym0;

  conv_encoder_k3 #(.G_X(GX), .G_Y(GY), .TAIL_EN(1'b1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_d), .bit_valid_i(bv0),
    .bit_last_i(blast), .bit_ready_o(br0), .sym_o(sym0), .sym_valid_o(sv0),
    .sym_last_o(sl0), .sym_ready_i(sym_ready), .busy_o(busy0), .frame_len_o(fl0)
  );

  conv_encoder_k3 #(.G_X(GX), .G_Y(GY), .TAIL_EN(1'b0), .CNT_W(3)) dut_nt (
    .clk_i(clk), .rst_i(rst), .bit_i(bit_d), .bit_valid_i(bv1),
    .bit_last_i(blast), .bit_ready_o(br1), .sym_o(sym1), .sym_valid_o(sv1),
    .sym_last_o(sl1), .sym_ready_i(sym_ready), .busy_o(busy1), .frame_len_o(fl1)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [1:0] items_q[$];   // {bit, last}
  logic [2:0] exp_q[$];     // {X, Y, last}
  int         explen_q[$];

  logic [2:0] got0[$], got1[$];
  int         flg0[$], flg1[$];
  logic       pend0 = 1'b0, pend1 = 1'b0;

  // Symbol monitors: record every handshake, and frame_len one cycle after a
  // closing handshake.
  always @(negedge clk) begin
    if (rst) pend0 <= 1'b0;
    else begin
      if (pend0) begin flg0.push_back(int'(fl0)); pend0 <= 1'b0; end
      if (sv0 && sym_ready) begin
        got0.push_back({sym0, sl0});
        if (sl0) pend0 <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) pend1 <= 1'b0;
    else begin
      if (pend1) begin flg1.push_back(int'(fl1)); pend1 <= 1'b0; end
      if (sv1 && sym_ready) begin
        got1.push_back({sym1, sl1});
        if (sl1) pend1 <= 1'b1;
      end
    end
  end

  // Reference: each frame is a plain bit list (zeros before it); the symbol
  // for bit j is the GF(2) convolution of the generator with bits j, j-1, j-2.
  task automatic build_expect(input bit tail_en, input int cnt_w);
    bit fr[$];
    int lim;
    lim = (1 << cnt_w) - 1;
    exp_q.delete();
    explen_q.delete();
    foreach (items_q[i]) begin
      fr.push_back(items_q[i][1]);
      if (items_q[i][0]) begin
        if (tail_en) begin fr.push_back(1'b0); fr.push_back(1'b0); end
        for (int j = 0; j < fr.size(); j++) begin
          bit u, p1, p2, x, y;
          u  = fr[j];
          p1 = (j >= 1) ? fr[j-1] : 1'b0;
          p2 = (j >= 2) ? fr[j-2] : 1'b0;
          x  = (GX[2] & u) ^ (GX[1] & p1) ^ (GX[0] & p2);
          y  = (GY[2] & u) ^ (GY[1] & p1) ^ (GY[0] & p2);
          exp_q.push_back({x, y, (j == fr.size() - 1)});
        end
        explen_q.push_back((fr.size() > lim) ? lim : fr.size());
        fr.delete();
      end
    end
  endtask

  // Drives items_q into the selected encoder. mode 0: ready high,
  // 1: random ready, 2: ready low for cycles 2..4. Starts and ends #1 after
  // a rising edge. Checks hold-while-stalled behaviour whenever it occurs.
  task automatic run_frame(input int mode, input int max_cycles);
    int idx, n;
    bit prev_stall;
    logic [1:0] prev_sym;
    idx = 0;
    n = items_q.size();
    prev_stall = 1'b0;
    prev_sym = 2'b00;
    got0.delete(); got1.delete(); flg0.delete(); flg1.delete();
    for (int c = 0; ; c++) begin
      if (c >= max_cycles) begin
        total_cnt++;
        $display("FAIL run_timeout: accepted %0d of %0d bits, busy=%0b", idx, n, busy_s);
        break;
      end
      case (mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = ($urandom_range(0, 3) != 0);
        default: sym_ready = !(c >= 2 && c <= 4);
      endcase
      if (idx < n) begin
        bv = 1'b1; bit_d = items_q[idx][1]; blast = items_q[idx][0];
      end else begin
        bv = 1'b0; bit_d = 1'b0; blast = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        total_cnt++;
        if (sv_s !== 1'b1 || sym_s !== prev_sym)
          $display("FAIL stall_hold: got valid=%0b sym=%b, need valid=1 sym=%b", sv_s, sym_s, prev_sym);
        else pass_cnt++;
      end
      if (sv_s && !sym_ready) begin
        total_cnt++;
        if (br_s !== 1'b0) $display("FAIL stall_bit_ready: got %0b, need 0", br_s);
        else pass_cnt++;
      end
      prev_stall = sv_s && !sym_ready;
      prev_sym = sym_s;
      if (bv && br_s) idx++;
      else if (idx >= n && !busy_s) break;
      @(posedge clk); #1;
    end
    bv = 1'b0; bit_d = 1'b0; blast = 1'b0; sym_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; bv = 1'b0; bit_d = 1'b0; blast = 1'b0; sym_ready = 1'b1; sel = 1'b0;
    #3;
    total_cnt++;
    if ({sv0, sym0, sl0, busy0, br0} !== 6'b000001 || fl0 !== 16'd0)
      $display("FAIL reset_tail: got v=%0b s=%b l=%0b busy=%0b rdy=%0b len=%0d, need 0/00/0/0/1/0",
               sv0, sym0, sl0, busy0, br0, fl0);
    else pass_cnt++;
    total_cnt++;
    if ({sv1, sym1, sl1, busy1, br1} !== 6'b000001 || fl1 !== 3'd0)
      $display("FAIL reset_notail: got v=%0b s=%b l=%0b busy=%0b rdy=%0b len=%0d, need 0/00/0/0/1/0",
               sv1, sym1, sl1, busy1, br1, fl1);
    else pass_cnt++;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Cycle-by-cycle: one-cycle latency, bit_ready low through TAIL.
  task automatic test_single_bit;
    logic [4:0] want [4];   // {valid, sym, last, bit_ready}
    want[0] = 5'b1_11_0_0;
    want[1] = 5'b1_10_0_0;
    want[2] = 5'b1_11_1_1;
    want[3] = 5'b0_11_1_1;
    sel = 1'b0; sym_ready = 1'b1;
    bv = 1'b1; bit_d = 1'b1; blast = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (br0 !== 1'b1) $display("FAIL single_ready_idle: got %0b, need 1", br0);
    else pass_cnt++;
    @(posedge clk); #1;
    bv = 1'b0; blast = 1'b0; bit_d = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({sv0, sym0, sl0, br0} !== want[k])
        $display("FAIL single_cycle%0d: got {v,sym,last,rdy}=%b, need %b", k, {sv0, sym0, sl0, br0}, want[k]);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    total_cnt++;
    if (fl0 !== 16'd3 || busy0 !== 1'b0)
      $display("FAIL single_len: got len=%0d busy=%0b, need 3/0", fl0, busy0);
    else pass_cnt++;
  endtask

  task automatic test_frame(input string name, input int mode, input bit s);
    logic [2:0] g[$];
    int fl[$];
    sel = s;
    build_expect(!s, s ? 3 : 16);
    run_frame(mode, 30 * items_q.size() + 40);
    g  = s ? got1 : got0;
    fl = s ? flg1 : flg0;
    total_cnt++;
    if (g.size() != exp_q.size())
      $display("FAIL %s_count: got %0d symbols, need %0d", name, g.size(), exp_q.size());
    else pass_cnt++;
    foreach (exp_q[i]) begin
      total_cnt++;
      if (i >= g.size() || g[i] !== exp_q[i])
        $display("FAIL %s_sym%0d: got {sym,last}=%b, need %b", name, i,
                 (i < g.size()) ? g[i] : 3'bxxx, exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (fl.size() != explen_q.size())
      $display("FAIL %s_frames: got %0d frame lengths, need %0d", name, fl.size(), explen_q.size());
    else pass_cnt++;
    foreach (explen_q[i]) begin
      total_cnt++;
      if (i >= fl.size() || fl[i] != explen_q[i])
        $display("FAIL %s_len%0d: got %0d, need %0d", name, i,
                 (i < fl.size()) ? fl[i] : -1, explen_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_basic;
    items_q = '{2'b10, 2'b00, 2'b10, 2'b11};
    test_frame("basic", 0, 1'b0);
  endtask

  task automatic test_stall;
    items_q = '{2'b10, 2'b00, 2'b10, 2'b11};
    test_frame("stall", 2, 1'b0);
  endtask

  task automatic test_back_to_back;
    items_q = '{2'b10, 2'b11, 2'b11};
    test_frame("b2b", 0, 1'b0);
  endtask

  task automatic test_no_tail;
    items_q = '{2'b10, 2'b11, 2'b11};
    test_frame("notail", 0, 1'b1);
    // 9 bits saturate the 3-bit counter at 7; the following frame restarts at 0.
    items_q.delete();
    for (int i = 0; i < 9; i++) items_q.push_back({1'(i % 2), (i == 8)});
    items_q.push_back(2'b11);
    test_frame("saturate", 0, 1'b1);
  endtask

  task automatic test_reset_mid;
    sel = 1'b0; sym_ready = 1'b1;
    bv = 1'b1; bit_d = 1'b1; blast = 1'b0;
    @(posedge clk); #1;
    bit_d = 1'b0;
    @(posedge clk); #1;
    bv = 1'b0; bit_d = 1'b0;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({sv0, sym0, sl0, busy0} !== 5'b0 || fl0 !== 16'd0)
      $display("FAIL reset_mid: got v=%0b s=%b l=%0b busy=%0b len=%0d, need all 0",
               sv0, sym0, sl0, busy0, fl0);
    else pass_cnt++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    items_q = '{2'b10, 2'b00, 2'b10, 2'b11};
    test_frame("after_reset", 0, 1'b0);
  endtask

  task automatic test_random;
    for (int it = 0; it < 12; it++) begin
      int nf;
      bit s;
      s = 1'($urandom_range(0, 1));
      nf = $urandom_range(1, 3);
      items_q.delete();
      for (int f = 0; f < nf; f++) begin
        int len;
        len = $urandom_range(1, 9);
        for (int b = 0; b < len; b++)
          items_q.push_back({1'($urandom_range(0, 1)), (b == len - 1)});
      end
      test_frame($sformatf("rand%0d", it), 1, s);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_bit;
    test_basic;
    test_stall;
    test_back_to_back;
    test_no_tail;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
